// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: turns each MEM-stage load/store into one registered
// MREQ/ACKD handshake, stalls the pipeline meanwhile, and aligns big-endian data.
module dmem_bus_if #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size_in,
  input  logic        load_unsigned,
  input  logic [31:0] address_in,
  input  logic [31:0] data_write_in,
  output logic [31:0] rdata_out,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] DAD,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  output logic [31:0] DWDT,
  input  logic [31:0] DDT,
  input  logic        ACKD
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             unsigned_q;
  logic             req;
  logic             misaligned;
  logic [31:0]      store_data;
  logic [31:0]      load_data;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;

  assign req   = mem_read | mem_write;
  assign stall = (state == REQ) || ((state == IDLE) && req);

  // Request-side decode: alignment check and byte-lane replication of store data.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    misaligned = 1'b0;
    store_data = data_write_in;
    case (size_in)
      2'b10: store_data = {4{data_write_in[7:0]}};
      2'b01: begin
        store_data = {2{data_write_in[15:0]}};
        misaligned = address_in[0];
      end
      default: misaligned = (address_in[1:0] != 2'b00);
    endcase
  end

  // Big-endian load lane select from the registered address, then extension.
  always_comb begin
    byte_lane = DDT[31:24];
    half_lane = DAD[1] ? DDT[15:0] : DDT[31:16];
    load_data = DDT;
    case (DAD[1:0])
      2'b01:   byte_lane = DDT[23:16];
      2'b10:   byte_lane = DDT[15:8];
      2'b11:   byte_lane = DDT[7:0];
      default: byte_lane = DDT[31:24];
    endcase
    case (SIZE)
      2'b10:   load_data = unsigned_q ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_data = unsigned_q ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_data = DDT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      unsigned_q <= 1'b0;
      rdata_out  <= '0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      DAD        <= '0;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
      DWDT       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req && misaligned) begin
            addr_err  <= 1'b1;
            rdata_out <= '0;
            state     <= ERR;
          end else if (req) begin
            DAD        <= address_in;
            SIZE       <= size_in;
            WRITE      <= mem_write;
            DWDT       <= store_data;
            unsigned_q <= load_unsigned;
            MREQ       <= 1'b1;
            count      <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (ACKD) begin
            MREQ <= 1'b0;
            if (!WRITE) rdata_out <= load_data;
            state <= DONE;
          end else if (count == LAST) begin
            MREQ      <= 1'b0;
            bus_err   <= 1'b1;
            rdata_out <= '0;
            state     <= ERR;
          end else begin
            count <= count + 1'b1;
          end
        end
        // DONE/ERR always return to IDLE so the still-held request is not re-issued.
        default: state <= IDLE;
      endcase
    end
  end

endmodule
